apb_cmd_sequencer: RTL and testbench
====================================

Name: apb_cmd_sequencer

Overview:
- Upstream feeder for the APB master CSR port (reg_addr/reg_wdata/reg_enable/reg_write/reg_idle/reg_rdata).
- Accepts a stream of read/write commands on a valid/ready interface and buffers them in a command FIFO.
- Replays each command to the master as a single-cycle enable pulse, then waits for completion.
- Returns read data, and optionally write completions, on a valid/ready response interface.

Parameters:
- ADDR_WIDTH, 32, address width; must match the APB master.
- DATA_WIDTH, 32, data width; must match the APB master.
- FIFO_DEPTH, 4, command FIFO entries; power of 2, minimum 2.

Ports:
- pclk_i  in  1  clock
- prstn_i  in  1  asynchronous active-low reset
- cmd_valid_i  in  1  command offered
- cmd_ready_o  out  1  FIFO not full
- cmd_write_i  in  1  1=write, 0=read
- cmd_addr_i  in  ADDR_WIDTH  target address
- cmd_wdata_i  in  DATA_WIDTH  write data
- rsp_valid_o  out  1  response available
- rsp_ready_i  in  1  response consumed
- rsp_write_o  out  1  response belongs to a write
- rsp_rdata_o  out  DATA_WIDTH  read data (0 for writes)
- reg_addr_o  out  ADDR_WIDTH  to master reg_addr_i
- reg_wdata_o  out  DATA_WIDTH  to master reg_wdata_i
- reg_write_o  out  1  to master reg_write_i
- reg_enable_o  out  1  to master reg_enable_i
- reg_idle_i  in  1  from master reg_idle_o
- reg_rdata_i  in  DATA_WIDTH  from master reg_rdata_o
- fifo_level_o  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
- busy_o  out  1  FSM not in IDLE, or FIFO non-empty

Behaviour:
- Reset: all outputs and registers go to 0, FSM to S_IDLE, FIFO empty. cmd_ready_o=1 one cycle after reset deassertion.
- Push: a command is pushed when cmd_valid_i && cmd_ready_o. Data become poppable on the next cycle.
- Push at level FIFO_DEPTH-1 makes cmd_ready_o=0 on the next cycle.
- Simultaneous push and pop when full: not allowed, because ready is low. Push and pop in the same cycle at any other level keeps the level unchanged.
- The FSM has four states: S_IDLE, S_ISSUE, S_WAIT_ACK, S_WAIT_DONE.
- S_IDLE -> S_ISSUE when FIFO non-empty && !rsp_valid_o && reg_idle_i.
  - On that edge: pop the FIFO and register reg_addr_o, reg_wdata_o and reg_write_o.
- S_ISSUE: reg_enable_o=1 for exactly this one cycle, then go to S_WAIT_ACK.
- S_WAIT_ACK: reg_enable_o=0. Go to S_WAIT_DONE when reg_idle_i==0.
- S_WAIT_DONE: go to S_IDLE when reg_idle_i==1.
  - On that edge: rsp_rdata_o<=reg_rdata_i for reads, 0 for writes; rsp_write_o<=reg_write_o.
  - rsp_valid_o<=1 if response generation applies (see Optional Feature).
- reg_enable_o is always 0 for at least 3 cycles between pulses. This guarantees a rising edge on every command.
- reg_addr_o, reg_wdata_o and reg_write_o hold stable from S_ISSUE until the next S_ISSUE.
- Response: rsp_valid_o clears on rsp_valid_o && rsp_ready_i.
  - rsp_* outputs hold while valid && !ready.
  - A new command is not issued while rsp_valid_o=1; this provides response backpressure.
- Minimum command-to-command spacing with an ideal master (pready=1): 6 cycles.
- Mid-operation reset returns to the reset state. Queued commands are dropped and the response is lost.
- fifo_level_o is updated every cycle with the post-edge occupancy.

Optional Feature:
- Macro: APB_SEQ_WR_RSP_EN.
- Defined: writes also produce a response (rsp_write_o=1, rsp_rdata_o=0). Every command yields exactly one response.
- Undefined: only reads produce responses. Writes complete silently and never stall on rsp_ready_i, and rsp_write_o is constant 0.

Decomposition:
- Package apb_seq_pkg holds:
  - state enum (S_IDLE, S_ISSUE, S_WAIT_ACK, S_WAIT_DONE);
  - parameterized command struct {write, addr, wdata} or its packed width constant;
  - RSP_RDATA_WR constant = 0.
- Sub-module apb_seq_fifo: synchronous FIFO with push/pop/full/empty/level and storage DEPTH x (1+ADDR_WIDTH+DATA_WIDTH).

Test Plan:
- Single read to 0x0000_0010 with master returning prdata 0xDEAD_BEEF:
  - one reg_enable_o pulse, reg_write_o=0;
  - rsp_valid_o rises exactly on the cycle reg_idle_i returns to 1;
  - rsp_rdata_o=0xDEAD_BEEF.
- Write 0x0000_0020 <- 0x1234_5678:
  - reg_wdata_o=0x1234_5678 during the pulse;
  - with APB_SEQ_WR_RSP_EN, rsp_write_o=1 and rsp_rdata_o=0;
  - without it, rsp_valid_o stays 0.
- Push 5 commands back-to-back with FIFO_DEPTH=4 and the master stalled (pready=0):
  - cmd_ready_o drops after 4 accepted, fifo_level_o=4;
  - after release, all 5 are issued in order with addresses matching.
- Hold rsp_ready_i=0 with 2 reads queued:
  - second reg_enable_o pulse withheld;
  - rsp_* stable until ready, then second read issues.
- Master with 3 wait states per transfer: exactly one reg_enable_o pulse per command, each separated by ≥3 low cycles.
- Assert prstn_i in S_WAIT_DONE with 2 commands queued: all outputs 0, fifo_level_o=0, no further pulses after release.

Source files
------------

// File: rtl/apb_seq_pkg.sv
// Shared definitions for the APB command sequencer.
//   seq_state_e   : sequencer FSM states
//   cmd_width()   : packed command width {write, addr, wdata}
//   RSP_RDATA_WR  : read-data value returned with write responses
package apb_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_ACK,
    S_WAIT_DONE
  } seq_state_e;

  localparam int unsigned RSP_RDATA_WR = 0;

  function automatic int unsigned cmd_width(input int unsigned addr_width,
                                            input int unsigned data_width);
    return 1 + addr_width + data_width;
  endfunction

endpackage

// File: rtl/apb_seq_fifo.sv
// Synchronous command FIFO for the APB sequencer.
// Ports:
//   clk_i, rst_ni   : clock, asynchronous active-low reset
//   push_i, wdata_i : write side (push ignored when full)
//   pop_i, rdata_o  : read side, rdata_o shows the head entry (pop ignored when empty)
//   full_o, empty_o : occupancy flags
//   level_o         : current occupancy, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
module apb_seq_fifo #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned WIDTH   = 65,
  parameter int unsigned LEVEL_W = $clog2(DEPTH) + 1
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               push_i,
  input  logic [WIDTH-1:0]   wdata_i,
  input  logic               pop_i,
  output logic [WIDTH-1:0]   rdata_o,
  output logic               full_o,
  output logic               empty_o,
  output logic [LEVEL_W-1:0] level_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0]   mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [LEVEL_W-1:0] level;
  logic               do_push;
  logic               do_pop;

  assign full_o  = (level == LEVEL_W'(DEPTH));
  assign empty_o = (level == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem[rd_ptr];
  assign level_o = level;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (do_push && !do_pop) begin
        level <= level + LEVEL_W'(1);
      end else if (do_pop && !do_push) begin
        level <= level - LEVEL_W'(1);
      end
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= wdata_i;
  end

endmodule

// File: rtl/apb_cmd_sequencer.sv
// Upstream feeder for the APB master CSR port. Buffers read/write commands in a FIFO,
// replays each one as a single-cycle reg_enable_o pulse, waits for the master to go busy
// and back to idle, then returns read data on a valid/ready response port.
// Ports:
//   pclk_i, prstn_i        : clock, asynchronous active-low reset
//   cmd_*                  : command stream in (valid/ready)
//   rsp_*                  : response stream out (valid/ready)
//   reg_*                  : to/from the APB master CSR port
//   fifo_level_o, busy_o   : status
// Build option: define APB_SEQ_WR_RSP_EN to make writes produce a response as well;
// otherwise writes complete silently and rsp_write_o stays 0.
module apb_cmd_sequencer
  import apb_seq_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          pclk_i,
  input  logic                          prstn_i,
  input  logic                          cmd_valid_i,
  output logic                          cmd_ready_o,
  input  logic                          cmd_write_i,
  input  logic [ADDR_WIDTH-1:0]         cmd_addr_i,
  input  logic [DATA_WIDTH-1:0]         cmd_wdata_i,
  output logic                          rsp_valid_o,
  input  logic                          rsp_ready_i,
  output logic                          rsp_write_o,
  output logic [DATA_WIDTH-1:0]         rsp_rdata_o,
  output logic [ADDR_WIDTH-1:0]         reg_addr_o,
  output logic [DATA_WIDTH-1:0]         reg_wdata_o,
  output logic                          reg_write_o,
  output logic                          reg_enable_o,
  input  logic                          reg_idle_i,
  input  logic [DATA_WIDTH-1:0]         reg_rdata_i,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
  output logic                          busy_o
);

`ifdef APB_SEQ_WR_RSP_EN
  localparam bit WR_RSP = 1'b1;
`else
  localparam bit WR_RSP = 1'b0;
`endif

  localparam int unsigned CMD_W   = cmd_width(ADDR_WIDTH, DATA_WIDTH);
  localparam int unsigned LEVEL_W = $clog2(FIFO_DEPTH) + 1;

  seq_state_e          state;
  logic                cmd_ready;
  logic                rsp_valid;
  logic                rsp_write;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic [ADDR_WIDTH-1:0] reg_addr;
  logic [DATA_WIDTH-1:0] reg_wdata;
  logic                reg_write;
  logic                reg_enable;

  logic                push;
  logic                pop;
  logic [CMD_W-1:0]    fifo_wdata;
  logic [CMD_W-1:0]    fifo_rdata;
  logic                fifo_full;
  logic                fifo_empty;
  logic [LEVEL_W-1:0]  fifo_level;
  logic [LEVEL_W-1:0]  level_next;

  assign push       = cmd_valid_i && cmd_ready && !fifo_full;
  // Pop and issue are the same event; a pending response blocks the next issue.
  assign pop        = (state == S_IDLE) && !fifo_empty && !rsp_valid && reg_idle_i;
  assign fifo_wdata = {cmd_write_i, cmd_addr_i, cmd_wdata_i};

  apb_seq_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .WIDTH   (CMD_W),
    .LEVEL_W (LEVEL_W)
  ) u_fifo (
    .clk_i   (pclk_i),
    .rst_ni  (prstn_i),
    .push_i  (push),
    .wdata_i (fifo_wdata),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  always_comb begin
    level_next = fifo_level;
    if (push && !pop) begin
      level_next = fifo_level + LEVEL_W'(1);
    end else if (pop && !push) begin
      level_next = fifo_level - LEVEL_W'(1);
    end
  end

  always_ff @(posedge pclk_i or negedge prstn_i) begin
    if (!prstn_i) begin
      state      <= S_IDLE;
      cmd_ready  <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_write  <= 1'b0;
      rsp_rdata  <= '0;
      reg_addr   <= '0;
      reg_wdata  <= '0;
      reg_write  <= 1'b0;
      reg_enable <= 1'b0;
    end else begin
      // Ready is registered from post-edge occupancy, so it rises one cycle out of reset.
      cmd_ready <= (level_next != LEVEL_W'(FIFO_DEPTH));

      if (rsp_valid && rsp_ready_i) rsp_valid <= 1'b0;

      case (state)
        S_IDLE: begin
          if (pop) begin
            {reg_write, reg_addr, reg_wdata} <= fifo_rdata;
            reg_enable <= 1'b1;
            state      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          reg_enable <= 1'b0;
          state      <= S_WAIT_ACK;
        end
        S_WAIT_ACK: begin
          if (!reg_idle_i) state <= S_WAIT_DONE;
        end
        S_WAIT_DONE: begin
          if (reg_idle_i) begin
            state <= S_IDLE;
            if (WR_RSP || !reg_write) begin
              rsp_valid <= 1'b1;
              rsp_write <= WR_RSP && reg_write;
              rsp_rdata <= reg_write ? DATA_WIDTH'(RSP_RDATA_WR) : reg_rdata_i;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready_o  = cmd_ready;
  assign rsp_valid_o  = rsp_valid;
  assign rsp_write_o  = rsp_write;
  assign rsp_rdata_o  = rsp_rdata;
  assign reg_addr_o   = reg_addr;
  assign reg_wdata_o  = reg_wdata;
  assign reg_write_o  = reg_write;
  assign reg_enable_o = reg_enable;
  assign fifo_level_o = fifo_level;
  assign busy_o       = (state != S_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_apb_cmd_sequencer.sv
// Self-checking bench for apb_cmd_sequencer with a behavioural APB master and a
// command/response scoreboard. Honours APB_SEQ_WR_RSP_EN when defined.
module tb_apb_cmd_sequencer;

`ifdef APB_SEQ_WR_RSP_EN
  localparam bit WrRsp = 1'b1;
`else
  localparam bit WrRsp = 1'b0;
`endif

  logic        pclk;
  logic        prstn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_write;
  logic [31:0] rsp_rdata;
  logic [31:0] reg_addr;
  logic [31:0] reg_wdata;
  logic        reg_write;
  logic        reg_enable;
  logic        reg_idle;
  logic [31:0] reg_rdata;
  logic [2:0]  fifo_level;
  logic        busy;

  apb_cmd_sequencer #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .FIFO_DEPTH (4)
  ) dut (
    .pclk_i       (pclk),
    .prstn_i      (prstn),
    .cmd_valid_i  (cmd_valid),
    .cmd_ready_o  (cmd_ready),
    .cmd_write_i  (cmd_write),
    .cmd_addr_i   (cmd_addr),
    .cmd_wdata_i  (cmd_wdata),
    .rsp_valid_o  (rsp_valid),
    .rsp_ready_i  (rsp_ready),
    .rsp_write_o  (rsp_write),
    .rsp_rdata_o  (rsp_rdata),
    .reg_addr_o   (reg_addr),
    .reg_wdata_o  (reg_wdata),
    .reg_write_o  (reg_write),
    .reg_enable_o (reg_enable),
    .reg_idle_i   (reg_idle),
    .reg_rdata_i  (reg_rdata),
    .fifo_level_o (fifo_level),
    .busy_o       (busy)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- behavioural APB master ----------------
  int          wait_states = 0;
  logic        hold = 1'b0;   // forces the master to look busy
  logic        m_idle;
  logic        m_write;
  logic [31:0] m_addr;
  int          m_cnt;

  function automatic logic [31:0] rdata_for(input logic [31:0] a);
    return (a == 32'h10) ? 32'hDEAD_BEEF : (a ^ 32'h5A5A_0F0F);
  endfunction

  assign reg_idle = m_idle && !hold;

  always @(posedge pclk or negedge prstn) begin
    if (!prstn) begin
      m_idle    <= 1'b1;
      m_write   <= 1'b0;
      m_addr    <= '0;
      m_cnt     <= 0;
      reg_rdata <= '0;
    end else if (m_idle) begin
      if (reg_enable) begin
        m_idle  <= 1'b0;
        m_cnt   <= wait_states;
        m_addr  <= reg_addr;
        m_write <= reg_write;
      end
    end else if (m_cnt == 0) begin
      m_idle    <= 1'b1;
      // Junk on writes so a leak into rsp_rdata is visible.
      reg_rdata <= m_write ? 32'hFFFF_FFFF : rdata_for(m_addr);
    end else begin
      m_cnt <= m_cnt - 1;
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
  } cmd_t;
  typedef struct {
    logic        w;
    logic [31:0] d;
  } rsp_t;

  cmd_t exp_cmd_q[$];
  rsp_t exp_rsp_q[$];

  int          n_pulses = 0;
  int          n_rsp    = 0;
  int          gap;
  bit          seen_pulse;
  bit          inflight_rsp;
  bit          exp_rsp_rise;
  logic        prev_idle;
  logic        prev_rsp_valid;
  bit          prev_hold_rsp;
  logic [31:0] prev_rdata;
  logic        prev_write;

  always @(negedge pclk) begin
    bit   have;
    bit   rose;
    bit   idle_rise;
    cmd_t c;
    rsp_t r;
    if (!prstn) begin
      exp_cmd_q.delete();
      exp_rsp_q.delete();
      gap            = 0;
      seen_pulse     = 0;
      inflight_rsp   = 0;
      exp_rsp_rise   = 0;
      prev_idle      = reg_idle;
      prev_rsp_valid = 0;
      prev_hold_rsp  = 0;
    end else begin
      if (prev_hold_rsp) begin
        check_eq("rsp_hold_valid", rsp_valid, 1'b1);
        check_eq("rsp_hold_rdata", rsp_rdata, prev_rdata);
        check_eq("rsp_hold_write", rsp_write, prev_write);
      end

      // Response must appear on the first edge that samples reg_idle high again.
      rose = rsp_valid && !prev_rsp_valid;
      if (rose || exp_rsp_rise) check_eq("rsp_rise_timing", rose, exp_rsp_rise);
      idle_rise    = reg_idle && !prev_idle;
      exp_rsp_rise = idle_rise && inflight_rsp;
      if (idle_rise) inflight_rsp = 0;

      if (rsp_valid && rsp_ready) begin
        n_rsp++;
        have = (exp_rsp_q.size() != 0);
        check_eq("rsp_expected", have, 1'b1);
        if (have) begin
          r = exp_rsp_q.pop_front();
          check_eq("rsp_write", rsp_write, r.w);
          check_eq("rsp_rdata", rsp_rdata, r.d);
        end
      end

      if (reg_enable) begin
        n_pulses++;
        if (seen_pulse) check_eq("pulse_gap_ge3", gap >= 3, 1'b1);
        seen_pulse = 1;
        gap        = 0;
        have = (exp_cmd_q.size() != 0);
        check_eq("pulse_expected", have, 1'b1);
        if (have) begin
          c = exp_cmd_q.pop_front();
          check_eq("issue_write", reg_write, c.w);
          check_eq("issue_addr", reg_addr, c.a);
          check_eq("issue_wdata", reg_wdata, c.d);
          inflight_rsp = !c.w || WrRsp;
        end
      end else begin
        gap++;
      end

      prev_idle      = reg_idle;
      prev_rsp_valid = rsp_valid;
      prev_hold_rsp  = rsp_valid && !rsp_ready;
      prev_rdata     = rsp_rdata;
      prev_write     = rsp_write;
    end
  end

  // ---------------- driver helpers (all run at posedge + 1) ----------------
  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  task automatic push_cmd(input logic w, input logic [31:0] a, input logic [31:0] d);
    bit acc;
    cmd_t c;
    rsp_t r;
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    acc = 0;
    for (int i = 0; i < 200 && !acc; i++) begin
      @(negedge pclk);
      acc = cmd_ready;
      if (acc) begin
        c.w = w; c.a = a; c.d = d;
        exp_cmd_q.push_back(c);
        if (!w || WrRsp) begin
          r.w = w;
          r.d = w ? 32'h0 : rdata_for(a);
          exp_rsp_q.push_back(r);
        end
      end
      step();
    end
    check_eq("cmd_accepted", acc, 1'b1);
  endtask

  task automatic cmd_idle();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    bit done;
    done = 0;
    for (int i = 0; i < budget && !done; i++) begin
      step();
      done = !busy && !rsp_valid && reg_idle &&
             exp_cmd_q.size() == 0 && exp_rsp_q.size() == 0;
    end
    check_eq("drain", done, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    int  p0;
    int  r0;
    bit  ok;
    prstn     = 1'b0;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    rsp_ready = 1'b1;

    // Reset state
    repeat (3) @(posedge pclk);
    @(negedge pclk);
    check_eq("rst_cmd_ready", cmd_ready, 1'b0);
    check_eq("rst_rsp_valid", rsp_valid, 1'b0);
    check_eq("rst_enable", reg_enable, 1'b0);
    check_eq("rst_level", fifo_level, 3'd0);
    check_eq("rst_busy", busy, 1'b0);
    step();
    prstn = 1'b1;
    step();
    check_eq("ready_after_rst", cmd_ready, 1'b1);

    // Single read
    p0 = n_pulses; r0 = n_rsp;
    push_cmd(1'b0, 32'h10, 32'h0);
    cmd_idle();
    wait_drain(100);
    check_eq("read_pulses", n_pulses - p0, 1);
    check_eq("read_rsps", n_rsp - r0, 1);

    // Single write
    p0 = n_pulses; r0 = n_rsp;
    push_cmd(1'b1, 32'h20, 32'h1234_5678);
    cmd_idle();
    wait_drain(100);
    check_eq("write_pulses", n_pulses - p0, 1);
    check_eq("write_rsps", n_rsp - r0, WrRsp ? 1 : 0);

    // Five back-to-back commands with the master stalled
    p0 = n_pulses;
    hold = 1'b1;
    push_cmd(1'b0, 32'h100, 32'h0);
    push_cmd(1'b1, 32'h104, 32'hA1);
    push_cmd(1'b0, 32'h108, 32'h0);
    push_cmd(1'b1, 32'h10C, 32'hA3);
    check_eq("full_ready", cmd_ready, 1'b0);
    check_eq("full_level", fifo_level, 3'd4);
    check_eq("full_busy", busy, 1'b1);
    fork
      push_cmd(1'b0, 32'h110, 32'h0);
      begin
        repeat (4) step();
        hold = 1'b0;
      end
    join
    cmd_idle();
    wait_drain(300);
    check_eq("burst_pulses", n_pulses - p0, 5);

    // Response backpressure with two reads queued
    rsp_ready = 1'b0;
    push_cmd(1'b0, 32'h200, 32'h0);
    push_cmd(1'b0, 32'h204, 32'h0);
    cmd_idle();
    ok = 0;
    for (int i = 0; i < 100 && !ok; i++) begin
      step();
      ok = rsp_valid;
    end
    check_eq("bp_rsp_seen", ok, 1'b1);
    p0 = n_pulses;
    repeat (10) step();
    check_eq("bp_withheld", n_pulses - p0, 0);
    check_eq("bp_valid_held", rsp_valid, 1'b1);
    check_eq("bp_level", fifo_level, 3'd1);
    rsp_ready = 1'b1;
    wait_drain(100);
    check_eq("bp_second_issued", n_pulses - p0, 1);

    // Three wait states per transfer
    wait_states = 3;
    p0 = n_pulses;
    push_cmd(1'b1, 32'h300, 32'hCAFE_0001);
    push_cmd(1'b0, 32'h304, 32'h0);
    push_cmd(1'b0, 32'h308, 32'h0);
    cmd_idle();
    wait_drain(300);
    check_eq("ws_pulses", n_pulses - p0, 3);

    // Reset in S_WAIT_DONE with two commands queued
    wait_states = 20;
    push_cmd(1'b0, 32'h400, 32'h0);
    push_cmd(1'b0, 32'h404, 32'h0);
    push_cmd(1'b0, 32'h408, 32'h0);
    cmd_idle();
    ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      step();
      ok = !reg_idle && fifo_level == 3'd2;
    end
    check_eq("mid_busy_reached", ok, 1'b1);
    repeat (3) step();
    prstn = 1'b0;
    @(negedge pclk);
    check_eq("mid_rst_enable", reg_enable, 1'b0);
    check_eq("mid_rst_addr", reg_addr, 32'h0);
    check_eq("mid_rst_wdata", reg_wdata, 32'h0);
    check_eq("mid_rst_write", reg_write, 1'b0);
    check_eq("mid_rst_rsp", {rsp_valid, rsp_write, rsp_rdata}, 34'h0);
    check_eq("mid_rst_ready", cmd_ready, 1'b0);
    check_eq("mid_rst_level", fifo_level, 3'd0);
    check_eq("mid_rst_busy", busy, 1'b0);
    step();
    wait_states = 0;
    prstn = 1'b1;
    p0 = n_pulses;
    repeat (30) step();
    check_eq("post_rst_pulses", n_pulses - p0, 0);
    check_eq("post_rst_level", fifo_level, 3'd0);
    check_eq("post_rst_ready", cmd_ready, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
